lut_interp_16: RTL and testbench

- Linear-interpolation stage sitting directly downstream of the 16-bit LUT readers (sin_2pi / tanh_4 style).
- Accepts a Q15 argument on a valid/ready input and drives the LUT's read/ready handshake.
- Captures base_sample, next_sample and frac from the LUT, computes base + (next - base)·frac / 2^F, and presents the Q15 result on a valid/ready output.

---
 rtl/lut_interp_16.sv | 114 +++++++++++
 tb/tb_lut_interp_16.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_interp_16.sv
// lut_interp_16: linear interpolation between two LUT samples, Q15 argument in, Q15 result out.
// Define LUT_INTERP_ROUND_EN to round half-up on the final shift instead of flooring.
`ifndef LUT_FRAC_WIDTH
`define LUT_FRAC_WIDTH 4
`endif

module lut_interp_16 #(
    parameter int unsigned FRAC_W = `LUT_FRAC_WIDTH,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              lut_read,
    input  logic              lut_ready,
    output logic [DATA_W-1:0] lut_x,
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    input  logic [FRAC_W-1:0] lut_frac
);

    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned PROD_W = DIFF_W + FRAC_W + 1;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StMul, StAdd, StOut} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0]        lut_x_q;
    logic [DATA_W-1:0]        base_q;
    logic [DATA_W-1:0]        y_q;
    logic signed [DIFF_W-1:0] diff_q;
    logic [FRAC_W-1:0]        frac_q;
    logic signed [PROD_W-1:0] prod_q;

    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] frac_ext;
    logic signed [PROD_W-1:0] base_ext;
    logic signed [PROD_W-1:0] prod_adj;
    logic [DATA_W-1:0]        sum;

`ifdef LUT_INTERP_ROUND_EN
    localparam logic signed [PROD_W-1:0] RoundHalf = PROD_W'(1) << (FRAC_W - 1);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid && in_ready) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (lut_ready) state_d = StMul;
            StMul:   state_d = StAdd;
            StAdd:   state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; in_ready is masked during reset so it reads 0 while the LUT comes up
    always_comb begin
        in_ready  = (state_q == StIdle) && lut_ready && !reset;
        lut_read  = (state_q == StIssue);
        out_valid = (state_q == StOut);
        y         = y_q;
        lut_x     = lut_x_q;
    end

    // The diff is 17 bits wide so next-base never wraps; frac is zero-extended to stay positive
    always_comb begin
        diff_ext = {{(PROD_W-DIFF_W){diff_q[DIFF_W-1]}}, diff_q};
        frac_ext = {{(PROD_W-FRAC_W){1'b0}}, frac_q};
        base_ext = {{(PROD_W-DATA_W){base_q[DATA_W-1]}}, base_q};
`ifdef LUT_INTERP_ROUND_EN
        prod_adj = prod_q + RoundHalf;
`else
        prod_adj = prod_q;
`endif
        // Result lies between base and next, so the low DATA_W bits are exact
        sum = DATA_W'(base_ext + (prod_adj >>> FRAC_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lut_x_q <= '0;
            base_q  <= '0;
            diff_q  <= '0;
            frac_q  <= '0;
            prod_q  <= '0;
            y_q     <= '0;
        end else begin
            if (state_q == StIdle && in_valid && in_ready) lut_x_q <= x_in;
            if (state_q == StWait && lut_ready) begin
                base_q <= lut_base;
                diff_q <= {lut_next[DATA_W-1], lut_next} - {lut_base[DATA_W-1], lut_base};
                frac_q <= lut_frac;
            end
            if (state_q == StMul) prod_q <= diff_ext * frac_ext;
            if (state_q == StAdd) y_q <= sum;
        end
    end

endmodule

// File: tb/tb_lut_interp_16.sv
// Directed bench for lut_interp_16 with a behavioural 16-bit LUT (ready returns 4 edges after read).
// Expected values are hand-computed for FRAC_W=4; LUT_INTERP_ROUND_EN selects the rounded expectations.
`timescale 1ns/1ps

module tb_lut_interp_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        lut_read;
    logic        lut_ready;
    logic [15:0] lut_x;
    logic [15:0] lut_base;
    logic [15:0] lut_next;
    logic [3:0]  lut_frac;

    logic lut_hold;
    int   lut_cnt;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef LUT_INTERP_ROUND_EN
    localparam logic [15:0] NegExp = 16'h00F9;
`else
    localparam logic [15:0] NegExp = 16'h00F8;
`endif

    lut_interp_16 #(.FRAC_W(4), .DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .lut_read  (lut_read),
        .lut_ready (lut_ready),
        .lut_x     (lut_x),
        .lut_base  (lut_base),
        .lut_next  (lut_next),
        .lut_frac  (lut_frac)
    );

    always #5 clk = ~clk;

    // LUT model: drops ready at the edge sampling lut_read, raises it 4 edges later
    always @(posedge clk) begin
        if (reset)         lut_cnt <= 0;
        else if (lut_read) lut_cnt <= 4;
        else if (lut_cnt > 0) lut_cnt <= lut_cnt - 1;
    end
    assign lut_ready = (lut_cnt == 0) && !lut_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns #1 after the accept edge with in_valid dropped
    task automatic do_accept(input logic [15:0] x);
        int guard = 0;
        x_in     = x;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = 16'hBEEF;
    endtask

    // Starts #1 after the accept edge; counts edges until out_valid and lut_read pulses
    task automatic finish_txn(output logic [15:0] y_got, output int lat, output int reads);
        lat   = 0;
        reads = lut_read ? 1 : 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lut_read) reads++;
        end
        y_got = y;
    endtask

    task automatic run_txn(input string tag, input logic [15:0] x, input logic [15:0] base,
                           input logic [15:0] nxt, input logic [3:0] frac,
                           input logic [15:0] exp_y);
        logic [15:0] y_got;
        int lat, reads;
        lut_base = base;
        lut_next = nxt;
        lut_frac = frac;
        do_accept(x);
        finish_txn(y_got, lat, reads);
        check({tag, "_y"}, {16'b0, y_got}, {16'b0, exp_y});
        check({tag, "_latency"}, lat, 32'd8);
        check({tag, "_reads"}, reads, 32'd1);
        check({tag, "_lut_x"}, {16'b0, lut_x}, {16'b0, x});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] y_got;
        logic [15:0] y_held;
        int lat, reads;
        bit bad_y, bad_v, bad_r, bad_rd;

        reset     = 1'b1;
        in_valid  = 1'b0;
        x_in      = '0;
        out_ready = 1'b1;
        lut_hold  = 1'b0;
        lut_base  = '0;
        lut_next  = '0;
        lut_frac  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_y", {16'b0, y}, 32'd0);
        check("rst_lut_read", {31'b0, lut_read}, 32'd0);
        check("rst_lut_x", {16'b0, lut_x}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_txn("midpoint", 16'h1234, 16'h1000, 16'h2000, 4'd8, 16'h1800);
        run_txn("neg_slope", 16'h4321, 16'h0100, 16'h00F1, 4'd8, NegExp);
        run_txn("full_span", 16'h7FFF, 16'h8000, 16'h7FFF, 4'd15, 16'h6FFF);

        // Backpressure
        out_ready = 1'b0;
        lut_base  = 16'h0200;
        lut_next  = 16'h0300;
        lut_frac  = 4'd4;
        do_accept(16'h0A0A);
        finish_txn(y_got, lat, reads);
        check("bp_y", {16'b0, y_got}, 32'h0240);
        y_held = y;
        bad_y = 0; bad_v = 0; bad_r = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (y !== y_held) bad_y = 1;
            if (out_valid !== 1'b1) bad_v = 1;
            if (in_ready !== 1'b0) bad_r = 1;
        end
        check("bp_y_stable", {31'b0, bad_y}, 32'd0);
        check("bp_valid_held", {31'b0, bad_v}, 32'd0);
        check("bp_in_ready_low", {31'b0, bad_r}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);

        // Reset two cycles after the read pulse, while waiting on the LUT
        lut_base = 16'h0100;
        lut_next = 16'h0200;
        lut_frac = 4'd2;
        do_accept(16'h5555);
        check("mid_read_pulse", {31'b0, lut_read}, 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_y", {16'b0, y}, 32'd0);
        check("mid_rst_lut_read", {31'b0, lut_read}, 32'd0);
        check("mid_rst_lut_x", {16'b0, lut_x}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        bad_v = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad_v = 1;
        end
        check("mid_rst_discard", {31'b0, bad_v}, 32'd0);
        run_txn("after_rst", 16'h0001, 16'h0000, 16'h0010, 4'd4, 16'h0004);

        // LUT busy: nothing accepted or issued until lut_ready rises
        lut_hold = 1'b1;
        lut_base = 16'hF000;
        lut_next = 16'hF100;
        lut_frac = 4'd12;
        x_in     = 16'h2222;
        in_valid = 1'b1;
        bad_r = 0; bad_rd = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (in_ready !== 1'b0) bad_r = 1;
            if (lut_read !== 1'b0) bad_rd = 1;
        end
        check("busy_in_ready_low", {31'b0, bad_r}, 32'd0);
        check("busy_no_read", {31'b0, bad_rd}, 32'd0);
        lut_hold = 1'b0;
        #1;
        check("busy_release_in_ready", {31'b0, in_ready}, 32'd1);
        do_accept(16'h2222);
        check("busy_read_next_cycle", {31'b0, lut_read}, 32'd1);
        finish_txn(y_got, lat, reads);
        check("busy_y", {16'b0, y_got}, 32'h0000F0C0);
        check("busy_latency", lat, 32'd8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule
